// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the nibble sequencer that drives it.
package alu_pkg;

    // Datapath width of the combinational ALU.
    localparam int unsigned NIBBLE_W = 4;

    // Function select codes of the 4-bit ALU.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_NOT = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_LT  = 3'b110,
        ALU_EQ  = 3'b111
    } alu_func_e;

    // Sequencer command codes. Logic ops share their encoding with the ALU codes.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_SEQ = 3'b111
    } seq_op_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

    // Ops that run as a carry-chained addition through the ALU.
    function automatic logic is_arith(input seq_op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) || (op == OP_SEQ);
    endfunction

    // Ops that subtract: b is inverted by the sequencer and nibble 0 gets cin=1.
    function automatic logic is_subtract(input seq_op_e op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SEQ);
    endfunction

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU used beside the nibble sequencer.
module alu4
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic [2:0]          c,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] result,
    output logic                carry,
    output logic                ovf,
    output logic                zero
);

    logic [NIBBLE_W:0] sum;

    // Function decode; arithmetic uses a 5-bit sum to expose the carry out.
    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (alu_func_e'(c))
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
                result = sum[NIBBLE_W-1:0];
                carry  = sum[NIBBLE_W];
                ovf    = (a[NIBBLE_W-1] == b[NIBBLE_W-1]) &&
                         (result[NIBBLE_W-1] != a[NIBBLE_W-1]);
            end
            ALU_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, cin};
                result = sum[NIBBLE_W-1:0];
                carry  = sum[NIBBLE_W];
                ovf    = (a[NIBBLE_W-1] != b[NIBBLE_W-1]) &&
                         (result[NIBBLE_W-1] != a[NIBBLE_W-1]);
            end
            ALU_NOT: result = ~a;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_LT:  result = {{(NIBBLE_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_EQ:  result = {{(NIBBLE_W-1){1'b0}}, (a == b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs one WIDTH-bit operation as NIBBLES passes through an external 4-bit ALU,
// least significant nibble first, chaining the carry between passes.
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned WIDTH  = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                rst_n,
    // Command side
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    // Nibble ALU interface
    output logic [NIBBLE_W-1:0] alu_a,
    output logic [NIBBLE_W-1:0] alu_b,
    output logic [2:0]          alu_c,
    output logic                alu_cin,
    input  logic [NIBBLE_W-1:0] alu_result,
    input  logic                alu_carry,
    input  logic                alu_ovf,
    // Result side
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_res,
    output logic                out_carry,
    output logic                out_ovf,
    output logic                out_zero
);

    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    seq_state_e          state_q;
    seq_op_e             op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [IdxW-1:0]     idx_q;
    logic                carry_q;
    logic                diff_zero_q;   // running AND of "nibble result == 0"
    logic [WIDTH-1:0]    acc_q;         // nibbles completed so far
    logic [WIDTH-1:0]    res_q;
    logic                res_carry_q;
    logic                res_ovf_q;
    logic                res_zero_q;

    logic                arith;
    logic                subtract;
    logic                last_nibble;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [WIDTH-1:0]    diff_full;
    logic                diff_zero_full;
    logic [WIDTH-1:0]    res_final;

    // Handshake flags decode directly from the registered state.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_res   = res_q;
    assign out_carry = res_carry_q;
    assign out_ovf   = res_ovf_q;
    assign out_zero  = res_zero_q;

    // Select the current nibble and drive the ALU; idle/done/reset drive zeros.
    always_comb begin
        arith       = is_arith(op_q);
        subtract    = is_subtract(op_q);
        last_nibble = (idx_q == IdxW'(NIBBLES - 1));
        nib_a       = '0;
        nib_b       = '0;
        for (int k = 0; k < int'(NIBBLES); k++) begin
            if (idx_q == IdxW'(k)) begin
                nib_a = a_q[k*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
        alu_a   = '0;
        alu_b   = '0;
        alu_c   = '0;
        alu_cin = 1'b0;
        if (state_q == RUN) begin
            alu_a = nib_a;
            if (arith) begin
                // Subtraction is a + ~b + 1 on the ALU adder; the borrow chains as carry.
                alu_b   = subtract ? ~nib_b : nib_b;
                alu_c   = ALU_ADD;
                alu_cin = (idx_q == '0) ? subtract : carry_q;
            end else begin
                alu_b   = nib_b;
                alu_c   = op_q;
                alu_cin = 1'b0;
            end
        end
    end

    // Assemble the final wide result using the last nibble straight off the ALU.
    always_comb begin
        diff_full = acc_q;
        diff_full[(NIBBLES-1)*NIBBLE_W +: NIBBLE_W] = alu_result;
        diff_zero_full = diff_zero_q && (alu_result == '0);
        unique case (op_q)
            OP_SLT:  res_final = WIDTH'(alu_result[NIBBLE_W-1] ^ alu_ovf);
            OP_SEQ:  res_final = WIDTH'(diff_zero_full);
            default: res_final = diff_full;
        endcase
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            diff_zero_q <= 1'b1;
            acc_q       <= '0;
            res_q       <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q        <= seq_op_e'(in_op);
                        a_q         <= in_a;
                        b_q         <= in_b;
                        idx_q       <= '0;
                        carry_q     <= 1'b0;
                        diff_zero_q <= 1'b1;
                        acc_q       <= '0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    carry_q     <= alu_carry;
                    diff_zero_q <= diff_zero_q && (alu_result == '0);
                    for (int k = 0; k < int'(NIBBLES); k++) begin
                        if (idx_q == IdxW'(k)) begin
                            acc_q[k*NIBBLE_W +: NIBBLE_W] <= alu_result;
                        end
                    end
                    if (last_nibble) begin
                        idx_q       <= '0;
                        res_q       <= res_final;
                        res_carry_q <= arith && alu_carry;
                        res_ovf_q   <= ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_ovf;
                        res_zero_q  <= (res_final == '0);
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq paired with the 4-bit ALU.
module tb_alu_nibble_seq;
    import alu_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [2:0]    alu_c;
    logic          alu_cin;
    logic [3:0]    alu_result;
    logic          alu_carry;
    logic          alu_ovf;
    logic          alu_zero;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_res;
    logic          out_carry;
    logic          out_ovf;
    logic          out_zero;

    int checks   = 0;
    int failures = 0;

    alu_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_ovf    (alu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    alu4 u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .c      (alu_c),
        .cin    (alu_cin),
        .result (alu_result),
        .carry  (alu_carry),
        .ovf    (alu_ovf),
        .zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic o,
                         output logic z);
        logic [W:0] s;
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r = a - b;
                c = (a >= b);
                o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_NOT: r = ~a;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: begin
                r = {15'd0, ($signed(a) < $signed(b))};
                c = (a >= b);
            end
            default: begin
                r = {15'd0, (a == b)};
                c = (a >= b);
            end
        endcase
        z = (r == '0);
    endtask

    // Issue one command, wait for the result, hold it 'hold' cycles, then take it.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, output logic [W-1:0] r, output logic c,
                          output logic o, output logic z, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r = out_res;
        c = out_carry;
        o = out_ovf;
        z = out_zero;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[12];
    logic [W-1:0] corners[6];

    initial begin
        logic [W-1:0] r, er, held;
        logic         c, o, z, ec, eo, ez;
        int           lat;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        int           seen;

        vecs[0]  = '{OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{OP_SLT, 16'hFFFE, 16'h0003, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_SEQ, 16'h1234, 16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_SEQ, 16'h1234, 16'h1235, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_SLT, 16'h0003, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        corners  = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h00FF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_res",   {16'd0, out_res},   32'd0);
        chk("rst_flags",     {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
        chk("rst_alu_drive", {20'd0, alu_a, alu_b, alu_c, alu_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, r, c, o, z, lat);
            chk($sformatf("vec%0d_res", i),   {16'd0, r}, {16'd0, vecs[i].res});
            chk($sformatf("vec%0d_carry", i), {31'd0, c}, {31'd0, vecs[i].carry});
            chk($sformatf("vec%0d_ovf", i),   {31'd0, o}, {31'd0, vecs[i].ovf});
            chk($sformatf("vec%0d_zero", i),  {31'd0, z}, {31'd0, vecs[i].zero});
            chk($sformatf("vec%0d_latency", i), lat, NIB + 1);
        end

        // Randomized against the reference model
        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            model(op, a, b, er, ec, eo, ez);
            run_op(op, a, b, $urandom_range(0, 3), r, c, o, z, lat);
            chk($sformatf("rnd%0d_op%0d_res", n, op), {16'd0, r}, {16'd0, er});
            chk($sformatf("rnd%0d_op%0d_carry", n, op), {31'd0, c}, {31'd0, ec});
            chk($sformatf("rnd%0d_op%0d_ovf", n, op), {31'd0, o}, {31'd0, eo});
            chk($sformatf("rnd%0d_op%0d_zero", n, op), {31'd0, z}, {31'd0, ez});
            chk($sformatf("rnd%0d_latency", n), lat, NIB + 1);
        end

        // Backpressure: result held, new commands ignored
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        @(negedge clk);
        in_op = OP_XOR;
        in_a  = 16'hFFFF;
        in_b  = 16'h0000;
        seen  = 0;
        while (!out_valid && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        chk("bp_valid_reached", {31'd0, out_valid}, 32'd1);
        held = out_res;
        chk("bp_first_res", {16'd0, held}, 32'h3333);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_res", k), {16'd0, out_res}, 32'h3333);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("bp_no_ghost_op", seen, 0);

        // Reset while nibble 2 is in flight
        in_valid = 1'b1;
        in_op    = OP_SUB;
        in_a     = 16'h5678;
        in_b     = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_run", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_res",   {16'd0, out_res},   32'd0);
        chk("abort_flags",     {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
        chk("abort_alu_drive", {20'd0, alu_a, alu_b, alu_c, alu_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);

        // Sequencer still works after the abort
        run_op(OP_ADD, 16'h0F0F, 16'h0101, 0, r, c, o, z, lat);
        chk("post_abort_res", {16'd0, r}, 32'h1010);
        chk("post_abort_latency", lat, NIB + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
